// File: rtl/vcu108_video_monitor_pkg.sv
// Shared types and constants for the VCU108 video timing monitor.
package vcu108_video_monitor_pkg;

  localparam int CNT_W = 12;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_UNARMED  = 2'd0,
    ST_CHECKING = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  // Bit positions inside the sticky error vector.
  localparam int ERR_OVF     = 0;
  localparam int ERR_WIDTH   = 1;
  localparam int ERR_TIMEOUT = 2;

  // Increment that sticks at the top of the 12-bit range.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + cnt_t'(1);
  endfunction

  function automatic logic [15:0] rotl1(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

endpackage

// File: rtl/vcu108_video_monitor_if.sv
// Video source bundle: syncs, data enable and pixel word.
interface vcu108_video_monitor_if;
  logic        vsync;
  logic        hsync;
  logic        de;
  logic [15:0] data;

  modport master (output vsync, hsync, de, data);
  modport slave  (input  vsync, hsync, de, data);
endinterface

// File: rtl/vcu108_video_line_measure.sv
// Per-line measurement: input registering, sync edge detection,
// horizontal / active-width counters and the running pixel checksum.
module vcu108_video_line_measure
  import vcu108_video_monitor_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  vcu108_video_monitor_if.slave video,
  output logic                  frame_start_o,
  output logic                  line_start_o,
  output cnt_t                  ended_len_o,
  output cnt_t                  line_len_o,
  output cnt_t                  ended_act_o,
  output logic [15:0]           checksum_o,
  output logic                  ovf_o
);

  logic        vs_q, hs_q, de_q, vs_prev_q, hs_prev_q;
  logic [15:0] data_q;
  cnt_t        h_cnt_q, act_cnt_q, line_len_q;
  logic [15:0] csum_q;

  assign frame_start_o = vs_q & ~vs_prev_q;
  assign line_start_o  = hs_q & ~hs_prev_q;
  // Length of the line closing at this line start (counter value plus one).
  assign ended_len_o   = sat_inc(h_cnt_q);
  assign ended_act_o   = act_cnt_q;
  assign line_len_o    = line_len_q;
  assign checksum_o    = csum_q;
  assign ovf_o         = (h_cnt_q == CNT_MAX) |
                         (de_q & ~line_start_o & (act_cnt_q == CNT_MAX));

  // Register the raw video inputs once, then keep one more copy for edges.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      de_q      <= 1'b0;
      data_q    <= '0;
      vs_prev_q <= 1'b0;
      hs_prev_q <= 1'b0;
    end else begin
      vs_q      <= video.vsync;
      hs_q      <= video.hsync;
      de_q      <= video.de;
      data_q    <= video.data;
      vs_prev_q <= vs_q;
      hs_prev_q <= hs_q;
    end
  end

  // Line counters restart at each line start; checksum restarts at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q    <= '0;
      act_cnt_q  <= '0;
      line_len_q <= '0;
      csum_q     <= '0;
    end else begin
      if (line_start_o) begin
        h_cnt_q    <= '0;
        line_len_q <= ended_len_o;
        act_cnt_q  <= cnt_t'(de_q);
      end else begin
        h_cnt_q <= sat_inc(h_cnt_q);
        if (de_q) act_cnt_q <= sat_inc(act_cnt_q);
      end
      if (frame_start_o)
        csum_q <= de_q ? data_q : 16'h0000;
      else if (de_q)
        csum_q <= rotl1(csum_q) ^ data_q;
    end
  end

endmodule

// File: rtl/vcu108_video_monitor.sv
// Video timing monitor: frame-level counting, measurement outputs,
// lock tracking and vsync timeout.
module vcu108_video_monitor
  import vcu108_video_monitor_pkg::*;
#(
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT_LOG2 = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  vcu108_video_monitor_if.slave video,
  output logic [11:0]           h_total,
  output logic [11:0]           h_active,
  output logic [11:0]           v_total,
  output logic [11:0]           v_active,
  output logic [15:0]           frame_checksum,
  output logic                  frame_done,
  output logic                  locked,
  output logic [2:0]            error
);

  localparam logic [TIMEOUT_LOG2-1:0] TMO_ONE = 1;

  logic        frame_start, line_start, line_ovf;
  cnt_t        ended_len, line_len, ended_act;
  logic [15:0] checksum;

  vcu108_video_line_measure u_line (
    .clk           (clk),
    .reset         (reset),
    .video         (video),
    .frame_start_o (frame_start),
    .line_start_o  (line_start),
    .ended_len_o   (ended_len),
    .line_len_o    (line_len),
    .ended_act_o   (ended_act),
    .checksum_o    (checksum),
    .ovf_o         (line_ovf)
  );

  cnt_t        line_cnt_q, act_lines_q, first_act_q;
  logic        first_seen_q, meas_valid_q, frame_done_q;
  cnt_t        h_total_q, h_active_q, v_total_q, v_active_q;
  logic [15:0] csum_out_q;
  logic [2:0]  error_q;
  lock_state_e state_q;
  logic [3:0]  match_q;
  logic [TIMEOUT_LOG2-1:0] tmo_q;

  // A line closing with any de cycles counts as active and is width-checked.
  logic ended_active, width_err, frame_ovf, fire_done, timing_same, timeout;
  cnt_t h_total_d, h_active_d, v_total_d, v_active_d;
  logic [3:0] match_inc;

  assign ended_active = line_start & (ended_act != '0);
  assign width_err    = ended_active & first_seen_q & (ended_act != first_act_q);
  assign frame_ovf    = (line_start & ~frame_start & (line_cnt_q == CNT_MAX)) |
                        (ended_active & (act_lines_q == CNT_MAX));

  // Values for the frame closing now; a simultaneous hsync edge closes its last line.
  assign h_total_d  = line_start ? ended_len : line_len;
  assign h_active_d = first_seen_q ? first_act_q : (ended_active ? ended_act : '0);
  assign v_total_d  = line_cnt_q;
  assign v_active_d = ended_active ? sat_inc(act_lines_q) : act_lines_q;

  // The first frame start after reset or timeout only arms measurement.
  assign fire_done   = frame_start & (state_q != ST_UNARMED);
  // With no earlier measurement since arming there is nothing to differ from.
  assign timing_same = ~meas_valid_q |
                       ((h_total_d == h_total_q) && (h_active_d == h_active_q) &&
                        (v_total_d == v_total_q) && (v_active_d == v_active_q));
  assign timeout     = ~frame_start & (&tmo_q);
  assign match_inc   = match_q + 4'd1;

  assign h_total        = h_total_q;
  assign h_active       = h_active_q;
  assign v_total        = v_total_q;
  assign v_active       = v_active_q;
  assign frame_checksum = csum_out_q;
  assign frame_done     = frame_done_q;
  assign error          = error_q;
  assign locked         = (state_q == ST_LOCKED);

  // Per-frame line bookkeeping; line 0 of a new frame may start on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt_q   <= '0;
      act_lines_q  <= '0;
      first_act_q  <= '0;
      first_seen_q <= 1'b0;
    end else if (frame_start) begin
      line_cnt_q   <= cnt_t'(line_start);
      act_lines_q  <= '0;
      first_act_q  <= '0;
      first_seen_q <= 1'b0;
    end else if (line_start) begin
      line_cnt_q <= sat_inc(line_cnt_q);
      if (ended_active) begin
        act_lines_q <= sat_inc(act_lines_q);
        if (!first_seen_q) begin
          first_seen_q <= 1'b1;
          first_act_q  <= ended_act;
        end
      end
    end
  end

  // Measurement outputs load on frame_done; error flags are sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_q <= 1'b0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_total_q    <= '0;
      v_active_q   <= '0;
      csum_out_q   <= '0;
      error_q      <= '0;
    end else begin
      frame_done_q <= fire_done;
      if (fire_done) begin
        h_total_q  <= h_total_d;
        h_active_q <= h_active_d;
        v_total_q  <= v_total_d;
        v_active_q <= v_active_d;
        csum_out_q <= checksum;
      end
      if (line_ovf | frame_ovf) error_q[ERR_OVF]     <= 1'b1;
      if (width_err)            error_q[ERR_WIDTH]   <= 1'b1;
      if (timeout)              error_q[ERR_TIMEOUT] <= 1'b1;
    end
  end

  // Lock state machine with vsync watchdog; the watchdog wraps after firing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_UNARMED;
      match_q      <= '0;
      meas_valid_q <= 1'b0;
      tmo_q        <= '0;
    end else begin
      tmo_q <= frame_start ? '0 : tmo_q + TMO_ONE;
      if (timeout) begin
        state_q      <= ST_UNARMED;
        match_q      <= '0;
        meas_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_UNARMED: if (frame_start) begin
            state_q <= ST_CHECKING;
            match_q <= '0;
          end
          ST_CHECKING: if (fire_done) begin
            meas_valid_q <= 1'b1;
            if (timing_same) begin
              match_q <= match_inc;
              if (match_inc >= 4'(LOCK_FRAMES)) state_q <= ST_LOCKED;
            end else begin
              match_q <= '0;
            end
          end
          ST_LOCKED: if (fire_done) begin
            meas_valid_q <= 1'b1;
            if (!timing_same) begin
              state_q <= ST_CHECKING;
              match_q <= '0;
            end
          end
          default: state_q <= ST_UNARMED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vcu108_video_monitor.sv
// Randomized self-checking bench for vcu108_video_monitor with a frame-level model.
module tb_vcu108_video_monitor;

  localparam int LOCK_FRAMES  = 2;
  localparam int TIMEOUT_LOG2 = 8;
  localparam int DE_OFF       = 3;

  typedef struct packed {
    logic [11:0] ht, ha, vt, va;
  } timing_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vcu108_video_monitor_if video ();

  logic [11:0] h_total, h_active, v_total, v_active;
  logic [15:0] frame_checksum;
  logic        frame_done, locked;
  logic [2:0]  error;

  vcu108_video_monitor #(.LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT_LOG2(TIMEOUT_LOG2)) dut (
    .clk            (clk),
    .reset          (reset),
    .video          (video),
    .h_total        (h_total),
    .h_active       (h_active),
    .v_total        (v_total),
    .v_active       (v_active),
    .frame_checksum (frame_checksum),
    .frame_done     (frame_done),
    .locked         (locked),
    .error          (error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every frame_done pulse and the values it presents.
  int          fd_cnt = 0;
  timing_t     cap_t;
  logic [15:0] cap_cs;
  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      fd_cnt <= fd_cnt + 1;
      cap_t  <= '{ht: h_total, ha: h_active, vt: v_total, va: v_active};
      cap_cs <= frame_checksum;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Current frame description and the pixels actually sent.
  int          h_len, n_lines;
  int          widths[16];
  bit          fixed_px;
  logic [15:0] pix_q[$];

  // Reference model state.
  bit          armed;
  timing_t     meas_hist[$];
  timing_t     prev_t;
  logic [15:0] prev_cs;
  int          exp_fd;
  logic [2:0]  exp_err;
  bit          pend_werr;

  task automatic drive(input logic vs, input logic hs, input logic de, input logic [15:0] d);
    @(posedge clk);
    #1;
    video.vsync = vs;
    video.hsync = hs;
    video.de    = de;
    video.data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic set_std();
    h_len = 20; n_lines = 10; fixed_px = 1'b0;
    for (int l = 0; l < 16; l++) widths[l] = (l < 6) ? 12 : 0;
  endtask

  task automatic send_frame();
    logic [15:0] fixed_vals [2];
    fixed_vals[0] = 16'h0001;
    fixed_vals[1] = 16'h8000;
    pix_q.delete();
    for (int l = 0; l < n_lines; l++) begin
      for (int c = 0; c < h_len; c++) begin
        logic        on;
        logic [15:0] d;
        on = (c >= DE_OFF) && (c < DE_OFF + widths[l]);
        d  = 16'h0000;
        if (on) begin
          d = (fixed_px && pix_q.size() < 2) ? fixed_vals[pix_q.size()] : 16'($urandom);
          pix_q.push_back(d);
        end
        drive(l == 0 && c < 2, c < 2, on, d);
      end
    end
  endtask

  function automatic timing_t model_timing();
    timing_t t;
    int first = 0;
    int act = 0;
    for (int l = 0; l < n_lines; l++)
      if (widths[l] != 0) begin
        if (first == 0) first = widths[l];
        act++;
      end
    t.ht = 12'(h_len); t.ha = 12'(first); t.vt = 12'(n_lines); t.va = 12'(act);
    return t;
  endfunction

  function automatic logic [15:0] model_csum();
    logic [15:0] cs = 16'h0000;
    foreach (pix_q[i]) cs = {cs[14:0], cs[15]} ^ pix_q[i];
    return cs;
  endfunction

  // Any active line among the first `upto` lines whose width differs from the first one.
  function automatic bit width_err(input int upto);
    int first = 0;
    for (int l = 0; l < upto; l++)
      if (widths[l] != 0) begin
        if (first == 0) first = widths[l];
        else if (widths[l] != first) return 1'b1;
      end
    return 1'b0;
  endfunction

  // Lock = enough consecutive equal measurements since arming; a run that began
  // after a change needs one extra frame because the changed frame scores zero.
  function automatic bit model_locked();
    int n = meas_hist.size();
    int r = 1;
    int cnt;
    if (n == 0) return 1'b0;
    while (r < n && meas_hist[n-1-r] == meas_hist[n-1]) r++;
    cnt = (r == n) ? r : r - 1;
    return cnt >= LOCK_FRAMES;
  endfunction

  task automatic model_reset();
    armed = 1'b0; meas_hist.delete(); exp_err = '0; pend_werr = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    timing_t t;
    logic [15:0] cs;
    send_frame();
    t  = model_timing();
    cs = model_csum();
    if (width_err(n_lines - 1)) exp_err[1] = 1'b1;
    if (pend_werr) exp_err[1] = 1'b1;
    if (armed) begin
      exp_fd++;
      meas_hist.push_back(prev_t);
      check({tag, "_ht"}, cap_t.ht, prev_t.ht);
      check({tag, "_ha"}, cap_t.ha, prev_t.ha);
      check({tag, "_vt"}, cap_t.vt, prev_t.vt);
      check({tag, "_va"}, cap_t.va, prev_t.va);
      check({tag, "_cs"}, cap_cs, prev_cs);
    end else begin
      armed = 1'b1;
      meas_hist.delete();
    end
    check({tag, "_fd"}, fd_cnt, exp_fd);
    check({tag, "_lock"}, locked, model_locked());
    check({tag, "_err"}, error, exp_err);
    prev_t = t; prev_cs = cs; pend_werr = width_err(n_lines);
  endtask

  initial begin
    timing_t last;
    video.vsync = 1'b0; video.hsync = 1'b0; video.de = 1'b0; video.data = 16'h0000;
    exp_fd = 0;
    model_reset();

    // Reset state.
    reset = 1'b1;
    idle(4);
    check("rst_ht", h_total, 0);
    check("rst_ha", h_active, 0);
    check("rst_vt", v_total, 0);
    check("rst_va", v_active, 0);
    check("rst_cs", frame_checksum, 0);
    check("rst_fd", frame_done, 0);
    check("rst_lock", locked, 0);
    check("rst_err", error, 0);
    reset = 1'b0;
    idle(2);

    // Nominal 20x10 stream, 12 active pixels on 6 lines.
    set_std();
    for (int i = 0; i < 3; i++) run_frame("nom");
    check("nom_fd2", fd_cnt, 2);
    check("nom_ht20", cap_t.ht, 20);
    check("nom_ha12", cap_t.ha, 12);
    check("nom_vt10", cap_t.vt, 10);
    check("nom_va6", cap_t.va, 6);
    check("nom_locked", locked, 1);

    // Random timings, sometimes repeated so lock can be re-acquired.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        int act, w;
        h_len   = $urandom_range(24, 16);
        n_lines = $urandom_range(10, 6);
        act     = $urandom_range(n_lines, 1);
        w       = $urandom_range(h_len - 4, 1);
        for (int l = 0; l < 16; l++) widths[l] = (l < act) ? w : 0;
      end
      run_frame("rnd");
    end

    // Checksum of two known pixels.
    set_std();
    for (int l = 0; l < 16; l++) widths[l] = 0;
    widths[0] = 2;
    fixed_px  = 1'b1;
    run_frame("csum");
    set_std();
    run_frame("csum_next");
    check("csum_8002", cap_cs, 16'h8002);

    // Lock, then one short active line.
    for (int i = 0; i < 3; i++) run_frame("relock");
    widths[3] = 11;
    run_frame("short");
    set_std();
    run_frame("short_next");
    check("short_err1", error[1], 1);
    check("short_va", cap_t.va, 6);
    check("short_ha", cap_t.ha, 12);
    check("short_locked", locked, 1);

    // Vertical total change to 11 lines.
    n_lines = 11;
    run_frame("vt11_a");
    run_frame("vt11_b");
    check("vt11_unlock", locked, 0);
    run_frame("vt11_c");
    run_frame("vt11_d");
    check("vt11_relock", locked, 1);

    // Stop vsync: timeout 256 cycles after the last frame start.
    last = meas_hist[meas_hist.size() - 1];
    idle(251 - h_len * n_lines);
    check("tmo_before", locked, 1);
    idle(16);
    exp_err[2] = 1'b1;
    check("tmo_locked", locked, 0);
    check("tmo_err", error, exp_err);
    check("tmo_hold_ht", h_total, last.ht);
    check("tmo_hold_vt", v_total, last.vt);
    check("tmo_fd", fd_cnt, exp_fd);
    armed = 1'b0; meas_hist.delete(); pend_werr = 1'b0;

    // 5000 cycles without hsync while vsync keeps the monitor armed.
    drive(1, 1, 0, 0); drive(1, 1, 0, 0);
    for (int i = 0; i < 25; i++) begin
      idle(198);
      drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    end
    drive(0, 1, 0, 0); drive(0, 1, 0, 0);
    idle(10);
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    idle(5);
    exp_fd += 26;
    check("ovf_fd", fd_cnt, exp_fd);
    check("ovf_ht", cap_t.ht, 4095);
    check("ovf_err0", error[0], 1);

    // Reset in the middle of a frame.
    set_std();
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < h_len; c++)
        drive(l == 0 && c < 2, c < 2, c >= DE_OFF && c < DE_OFF + 12, 16'($urandom));
    exp_fd++;
    check("mid_fd_pre", fd_cnt, exp_fd);
    reset = 1'b1;
    idle(3);
    check("mid_ht", h_total, 0);
    check("mid_vt", v_total, 0);
    check("mid_cs", frame_checksum, 0);
    check("mid_lock", locked, 0);
    check("mid_err", error, 0);
    reset = 1'b0;
    model_reset();
    idle(2);
    run_frame("post_rst1");
    run_frame("post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
